fetch_pc: RTL
=============

FETCH_PC -- requirements
Module: fetch_pc

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC loaded on reset.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-003 Port rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 Port branch_taken  input  1  SHALL be a redirect request, sampled every cycle.
REQ-005 Port branch_target  input  32  SHALL be the redirect address.
REQ-006 Port imem_req  output  1  SHALL be the instruction-memory request.
REQ-007 Port imem_addr  output  32  SHALL be the fetch address, equal to the current PC.
REQ-008 Port imem_ack  input  1  SHALL be the one-cycle memory response strobe.
REQ-009 Port imem_rdata  input  32  SHALL be the instruction word, valid when imem_ack=1.
REQ-010 Port out_valid  output  1  SHALL flag a fetched instruction for the downstream select/decode stage.
REQ-011 Port out_ready  input  1  SHALL be downstream acceptance.
REQ-012 Port out_pc  output  32  SHALL be the address of out_instr.
REQ-013 Port out_instr  output  32  SHALL be the fetched instruction word.

Function
REQ-014 The FSM SHALL have two states: REQ (fetch outstanding) and HOLD (instruction presented).
REQ-015 imem_req SHALL be 1 exactly when state=REQ and rst=0; imem_addr SHALL equal the pc register at all times.
REQ-016 In REQ with imem_ack=1 and branch_taken=0, at the next edge: out_instr<=imem_rdata, out_pc<=pc, out_valid<=1, pc<=pc+4, state<=HOLD.
REQ-017 In REQ with imem_ack=0 and branch_taken=0, pc, outputs and state SHALL hold; imem_addr SHALL stay stable.
REQ-018 In HOLD, out_valid, out_pc and out_instr SHALL hold until out_ready=1.
REQ-019 In HOLD with out_ready=1 and branch_taken=0, at the next edge: out_valid<=0, state<=REQ. This produces a one-cycle bubble by design.
REQ-020 imem_ack in HOLD SHALL be ignored.
REQ-021 pc+4 SHALL be 32-bit modulo: 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-022 When branch_taken=1 in any state (rst=0), the next edge SHALL apply all of the following:
- pc<={branch_target[31:2],2'b00};
- out_valid<=0;
- state<=REQ.
REQ-023 Branch SHALL take priority over a simultaneous imem_ack: the response is discarded, and out_pc/out_instr are not updated.
REQ-024 Branch SHALL take priority over a simultaneous out_ready handshake in HOLD: the presented instruction counts as consumed, and no further output is produced for it.
REQ-025 Throughput SHALL be at most one instruction per 2 cycles; latency from imem_ack to out_valid=1 SHALL be 1 cycle.

Reset
REQ-026 While rst=1 at an edge:
- pc<=RESET_PC;
- state<=REQ;
- out_valid<=0;
- out_pc<=0;
- out_instr<=0.
REQ-027 rst SHALL override branch_taken, imem_ack and out_ready in the same cycle.
REQ-028 imem_req SHALL be 0 while rst=1 and SHALL be 1 in the first cycle after rst falls.
REQ-029 Reset mid-operation (in REQ awaiting ack, or in HOLD) SHALL abandon the fetch or instruction.
REQ-030 An imem_ack arriving in the cycle after reset release SHALL be accepted for address RESET_PC.

Verification
REQ-031 Reset release, RESET_PC=0, ack after 2 cycles with rdata=32'h0000_0013 -> imem_addr=0; then out_valid=1, out_pc=0, out_instr=32'h0000_0013 one cycle after ack; next imem_addr=4.
REQ-032 Backpressure: out_ready=0 for 5 cycles in HOLD -> out_valid, out_pc and out_instr constant; imem_req=0 throughout; out_ready=1 -> out_valid=0 next cycle, then imem_req=1.
REQ-033 Branch with same-cycle ack: pc=8, branch_target=32'h0000_0103, imem_ack=1 -> next imem_addr=32'h0000_0100, out_valid=0, out_pc unchanged.
REQ-034 Branch in HOLD with out_ready=0: target 32'h40 -> out_valid=0 next cycle, imem_req=1, imem_addr=32'h40.
REQ-035 Wrap: branch to 32'hFFFF_FFFC, ack -> out_pc=32'hFFFF_FFFC; next fetch address 32'h0000_0000.
REQ-036 Reset in HOLD with branch_taken=1 -> out_valid=0, imem_addr=RESET_PC, state REQ after release.

Source files
------------

// File: rtl/fetch_pc.sv
// fetch_pc: program-counter and instruction-fetch front end.
//
// The block alternates between two phases:
//   REQ  - a fetch is outstanding at imem_addr (= pc) and the block waits for imem_ack.
//   HOLD - the fetched word is presented on out_* until the downstream stage takes it.
//
// A taken branch redirects the pc from either phase. Any response or handshake
// in flight during that cycle is dropped. Because every fetch passes through
// HOLD, there is an intentional one-cycle bubble after each accepted instruction.
// This limits throughput to at most one instruction every two cycles.
module fetch_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  typedef enum logic {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic        out_valid_reg;
  logic [31:0] out_pc_reg;
  logic [31:0] out_instr_reg;

  // Sequential pc increment; the 32-bit width gives the modulo wrap naturally.
  logic [31:0] pc_inc;
  // Redirect addresses are forced word-aligned by clearing the two low bits.
  logic [31:0] redirect_pc;

  assign pc_inc      = pc_reg + 32'd4;
  assign redirect_pc = branch_target & 32'hFFFF_FFFC;

  // Control FSM plus pc and output registers.
  // Priority: reset, then branch, then the per-state ack/ready handling.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_REQ;
      pc_reg        <= RESET_PC;
      out_valid_reg <= 1'b0;
      out_pc_reg    <= 32'd0;
      out_instr_reg <= 32'd0;
    end else if (branch_taken) begin
      // The redirect wins over a same-cycle ack or ready. Whatever was in
      // flight or being presented is dropped, and the old out_pc/out_instr
      // values stay as they are.
      state_reg     <= S_REQ;
      pc_reg        <= redirect_pc;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_REQ: begin
          if (imem_ack) begin
            out_instr_reg <= imem_rdata;
            out_pc_reg    <= pc_reg;
            out_valid_reg <= 1'b1;
            pc_reg        <= pc_inc;
            state_reg     <= S_HOLD;
          end
        end
        S_HOLD: begin
          // Any imem_ack seen here is spurious and is ignored.
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= S_REQ;
          end
        end
        default: begin
          state_reg     <= S_REQ;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  // The request is qualified by rst so it drops in the same cycle reset is asserted.
  assign imem_req  = (state_reg == S_REQ) && !rst;
  assign imem_addr = pc_reg;
  assign out_valid = out_valid_reg;
  assign out_pc    = out_pc_reg;
  assign out_instr = out_instr_reg;

endmodule
